proporcional_pipe: RTL

//  Registered proportional-gain stage for the servo control loop: proporcional = sat(Kp * y).

---
 rtl/proporcional_pipe.sv | 88 ++++++++
 1 files changed

// File: rtl/proporcional_pipe.sv
// Registered proportional-gain stage: proporcional = sat(round(Kp * y)).
// Two-stage valid pipeline with a run-time loadable gain and live/sticky saturation flags.
module proporcional_pipe #(
  parameter int Magnitud = 17,
  parameter int Decimal  = 0,
  parameter int N        = Magnitud + Decimal + 1,
  parameter int KP_RESET = 18
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [N-1:0] kp_in,
  input  logic                kp_load,
  input  logic                valid_in,
  input  logic signed [N-1:0] y,
  output logic signed [N-1:0] proporcional,
  output logic                valid_out,
  output logic                sat,
  output logic                sat_sticky,
  input  logic                sat_clr
);

  // One guard bit above the full product so the rounding add can never wrap.
  localparam int W = 2 * N + 1;
  localparam logic signed [N-1:0] KP_INIT = N'(KP_RESET <<< Decimal);
  localparam logic signed [W-1:0] RND     = W'((2 ** Decimal) / 2);
  localparam logic signed [W-1:0] MAXV    = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [W-1:0] MINV    = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

  logic signed [N-1:0]   kp_act;
  logic signed [N-1:0]   y_r;
  logic signed [N-1:0]   k_r;
  logic                  v1;

  logic signed [2*N-1:0] prod;
  logic signed [W-1:0]   sum;
  logic signed [W-1:0]   rounded;
  logic signed [N-1:0]   clip_val;
  logic                  clip_flag;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    prod      = (2 * N)'(y_r) * (2 * N)'(k_r);
    sum       = W'(prod) + RND;
    rounded   = sum >>> Decimal;
    clip_val  = rounded[N-1:0];
    clip_flag = 1'b0;
    if (rounded > MAXV) begin
      clip_val  = MAXV[N-1:0];
      clip_flag = 1'b1;
    end else if (rounded < MINV) begin
      clip_val  = MINV[N-1:0];
      clip_flag = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kp_act       <= KP_INIT;
      y_r          <= '0;
      k_r          <= '0;
      v1           <= 1'b0;
      proporcional <= '0;
      valid_out    <= 1'b0;
      sat          <= 1'b0;
      sat_sticky   <= 1'b0;
    end else begin
      if (kp_load) kp_act <= kp_in;

      // Stage 1 captures the gain active before this edge, so a same-cycle load is not seen.
      v1 <= valid_in;
      if (valid_in) begin
        y_r <= y;
        k_r <= kp_act;
      end

      valid_out <= v1;
      if (v1) begin
        proporcional <= clip_val;
        sat          <= clip_flag;
      end

      if (v1 && clip_flag) sat_sticky <= 1'b1;
      else if (sat_clr)    sat_sticky <= 1'b0;
    end
  end

endmodule
